wash_cycle_sequencer: RTL and testbench
=======================================

WASH_CYCLE_SEQUENCER -- requirements
Module: wash_cycle_sequencer

Interface
REQ-001 SHALL have parameter BASE, default 4, meaning the base phase duration unit in clk cycles (legal range 1..1023).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin a cycle (level, sampled each clk).
REQ-005 SHALL have port door  input  1  1 = door open, 0 = closed.
REQ-006 SHALL have port pause  input  1  user hold request.
REQ-007 SHALL have port load  input  2  load size L (0..3), scales fill, wash and rinse durations.
REQ-008 SHALL have port extra_rinse  input  1  second rinse request (see Configuration).
REQ-009 SHALL have ports agitator, motor, pump, speed, water  output  1 each  actuator drives; speed 1 = high (spin), 0 = low.
REQ-010 SHALL have port door_lock  output  1  door interlock request.
REQ-011 SHALL have port held  output  1  sequence frozen by door or pause.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port phase  output  3  current state encoding.

Function
REQ-014 SHALL implement states, phase encodings: IDLE 0, FILL 1, WASH 2, DRAIN1 3, RINSE 4, DRAIN2 5, SPIN 6, DONE 7.
REQ-015 SHALL leave IDLE for FILL only when start=1, door=0 and pause=0 at the same edge; load and extra_rinse SHALL be latched at that edge.
REQ-016 SHALL ignore start in every state except IDLE.
REQ-017 SHALL set phase durations in unfrozen cycles: FILL BASE*(L+1), WASH 2*BASE*(L+1), DRAIN1/DRAIN2 BASE, RINSE BASE*(L+1), SPIN 2*BASE; L is the latched load.
REQ-018 SHALL load a 16-bit down-counter on phase entry and move to the next phase on the edge after it has been in the phase for exactly its duration.
REQ-019 SHALL sequence FILL->WASH->DRAIN1->RINSE->DRAIN2->SPIN->DONE->IDLE; DONE lasts exactly one cycle.
REQ-020 SHALL drive outputs as a Moore decode of state: FILL water; WASH agitator+motor; DRAIN1/DRAIN2 pump; RINSE water+agitator+motor; SPIN motor+speed+pump; IDLE/DONE all zero; done=1 only in DONE.
REQ-021 SHALL assert door_lock in FILL through SPIN, deasserted in IDLE and DONE.
REQ-022 SHALL, in FILL..SPIN, assert held whenever door=1 or pause=1; while held, counter and state freeze and agitator, motor, pump, speed, water are forced 0.
REQ-023 SHALL resume from the frozen count on the first cycle door=0 and pause=0, without reloading the counter.
REQ-024 SHALL keep held=0 in IDLE and DONE.

Reset
REQ-025 SHALL, on rst=1 at a rising edge, enter IDLE, clear counter and latched load/extra_rinse; all outputs 0 the following cycle; reset overrides start and all in-progress phases.

Configuration
REQ-026 SHALL honour macro EXTRA_RINSE_EN: when defined and extra_rinse latched 1, DRAIN2 is followed by a second RINSE then DRAIN2 (same durations) before SPIN; tracked by a one-bit pass flag cleared on start/reset.
REQ-027 SHALL, without EXTRA_RINSE_EN, keep port extra_rinse present but ignored; sequence per REQ-019.

Verification
REQ-028 SHALL cover: BASE=4, load=0, start pulse at edge 0 -> phase 1 from cycle 1, FILL 4, WASH 8, DRAIN1 4, RINSE 4, DRAIN2 4, SPIN 8 cycles, done=1 at cycle 33 only, IDLE at 34.
REQ-029 SHALL cover: load=3, BASE=4 -> FILL 16, WASH 32, RINSE 16 cycles; load changed to 0 mid-cycle has no effect.
REQ-030 SHALL cover: door=1 for 5 cycles at WASH count 3 -> held=1, actuators 0, phase stays 2; WASH completes 3 cycles after door=0.
REQ-031 SHALL cover: start=1 with door=1 in IDLE -> stays IDLE, door_lock=0; start during SPIN -> ignored.
REQ-032 SHALL cover: rst=1 during SPIN -> next cycle phase=0, all outputs 0, no done pulse.
REQ-033 SHALL cover: EXTRA_RINSE_EN defined, extra_rinse=1 at start, BASE=4, load=0 -> RINSE and DRAIN2 each occur twice, done at cycle 41; macro undefined -> done at cycle 33.

Source files
------------

// File: rtl/wash_cycle_sequencer.sv
// wash_cycle_sequencer
// Washing-machine phase sequencer: FILL, WASH, DRAIN1, RINSE, DRAIN2, SPIN, DONE.
// Each phase runs for a load-scaled number of unfrozen clock cycles, tracked by a
// 16-bit down-counter loaded on phase entry. Door-open or pause freezes the
// sequence and silences the actuators.
// Optional feature macro: EXTRA_RINSE_EN. When defined, a latched extra_rinse
// request inserts a second RINSE + DRAIN2 pass before SPIN.
module wash_cycle_sequencer #(
    parameter int BASE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       door,
    input  logic       pause,
    input  logic [1:0] load,
    input  logic       extra_rinse,
    output logic       agitator,
    output logic       motor,
    output logic       pump,
    output logic       speed,
    output logic       water,
    output logic       door_lock,
    output logic       held,
    output logic       done,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FILL   = 3'd1,
        S_WASH   = 3'd2,
        S_DRAIN1 = 3'd3,
        S_RINSE  = 3'd4,
        S_DRAIN2 = 3'd5,
        S_SPIN   = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    localparam logic [15:0] BASE_U = 16'(BASE);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  load_q, load_d;
    logic        active;

`ifdef EXTRA_RINSE_EN
    logic xr_q, xr_d;
    logic pass_q, pass_d;
`else
    logic extra_rinse_unused;
    assign extra_rinse_unused = extra_rinse;
`endif

    // Counter reload value for a phase: its duration minus one, since the
    // entry cycle itself is the first cycle spent in the phase.
    function automatic logic [15:0] phase_len(input state_t s, input logic [1:0] l);
        logic [15:0] scaled;
        logic [15:0] len;
        scaled = BASE_U * ({14'd0, l} + 16'd1);
        case (s)
            S_FILL:             len = scaled;
            S_WASH:             len = scaled << 1;
            S_DRAIN1, S_DRAIN2: len = BASE_U;
            S_RINSE:            len = scaled;
            S_SPIN:             len = BASE_U << 1;
            default:            len = 16'd1;
        endcase
        return len - 16'd1;
    endfunction

    assign active = (state_q != S_IDLE) && (state_q != S_DONE);
    assign held   = active && (door || pause);

    // Next-state: start acceptance, per-phase countdown and phase ordering.
    always_comb begin
        state_t nxt;
        state_d = state_q;
        cnt_d   = cnt_q;
        load_d  = load_q;
        nxt     = S_IDLE;
`ifdef EXTRA_RINSE_EN
        xr_d    = xr_q;
        pass_d  = pass_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start && !door && !pause) begin
                    state_d = S_FILL;
                    load_d  = load;
                    cnt_d   = phase_len(S_FILL, load);
`ifdef EXTRA_RINSE_EN
                    xr_d    = extra_rinse;
                    pass_d  = 1'b0;
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = 16'd0;
            end
            default: begin
                if (!held) begin
                    if (cnt_q == 16'd0) begin
                        case (state_q)
                            S_FILL:   nxt = S_WASH;
                            S_WASH:   nxt = S_DRAIN1;
                            S_DRAIN1: nxt = S_RINSE;
                            S_RINSE:  nxt = S_DRAIN2;
                            S_DRAIN2: begin
`ifdef EXTRA_RINSE_EN
                                if (xr_q && !pass_q) begin
                                    nxt    = S_RINSE;
                                    pass_d = 1'b1;
                                end else begin
                                    nxt = S_SPIN;
                                end
`else
                                nxt = S_SPIN;
`endif
                            end
                            S_SPIN:   nxt = S_DONE;
                            default:  nxt = S_IDLE;
                        endcase
                        state_d = nxt;
                        cnt_d   = (nxt == S_DONE) ? 16'd0 : phase_len(nxt, load_q);
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
            end
        endcase
    end

    // State, counter and latched cycle options; reset returns to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            load_q  <= 2'd0;
`ifdef EXTRA_RINSE_EN
            xr_q    <= 1'b0;
            pass_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
`ifdef EXTRA_RINSE_EN
            xr_q    <= xr_d;
            pass_q  <= pass_d;
`endif
        end
    end

    // Moore actuator decode, silenced while the sequence is held.
    always_comb begin
        agitator  = 1'b0;
        motor     = 1'b0;
        pump      = 1'b0;
        speed     = 1'b0;
        water     = 1'b0;
        door_lock = active;
        done      = (state_q == S_DONE);
        phase     = state_q;
        if (!held) begin
            case (state_q)
                S_FILL:             water = 1'b1;
                S_WASH:             begin agitator = 1'b1; motor = 1'b1; end
                S_DRAIN1, S_DRAIN2: pump = 1'b1;
                S_RINSE:            begin water = 1'b1; agitator = 1'b1; motor = 1'b1; end
                S_SPIN:             begin motor = 1'b1; speed = 1'b1; pump = 1'b1; end
                default:            ;
            endcase
        end
    end

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// Testbench for wash_cycle_sequencer. The reference model expands a cycle's
// phase list into a per-cycle expected-phase queue; held cycles simply do not
// advance the queue pointer.
module tb_wash_cycle_sequencer;

    localparam int B = 4;

    logic       clk = 1'b0;
    logic       rst, start, door, pause, extra_rinse;
    logic [1:0] load;
    logic       agitator, motor, pump, speed, water, door_lock, held, done;
    logic [2:0] phase;

    int n_tests = 0;
    int n_fail  = 0;
    int sched[$];

    always #5 clk = ~clk;

    wash_cycle_sequencer #(.BASE(B)) dut (
        .clk(clk), .rst(rst), .start(start), .door(door), .pause(pause),
        .load(load), .extra_rinse(extra_rinse),
        .agitator(agitator), .motor(motor), .pump(pump), .speed(speed),
        .water(water), .door_lock(door_lock), .held(held), .done(done),
        .phase(phase)
    );

    function automatic bit ext_enabled();
`ifdef EXTRA_RINSE_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic push_n(input int p, input int n);
        for (int i = 0; i < n; i++) sched.push_back(p);
    endtask

    // Expected phase per unfrozen cycle, from the first FILL cycle to the IDLE after DONE.
    task automatic build_sched(input int l, input bit xr);
        sched.delete();
        push_n(1, B * (l + 1));
        push_n(2, 2 * B * (l + 1));
        push_n(3, B);
        push_n(4, B * (l + 1));
        push_n(5, B);
        if (ext_enabled() && xr) begin
            push_n(4, B * (l + 1));
            push_n(5, B);
        end
        push_n(6, 2 * B);
        push_n(7, 1);
        push_n(0, 1);
    endtask

    // {agitator, motor, pump, speed, water}
    function automatic logic [4:0] exp_act(input int p, input bit h);
        if (h) return 5'b00000;
        case (p)
            1:       return 5'b00001;
            2:       return 5'b11000;
            3, 5:    return 5'b00100;
            4:       return 5'b11001;
            6:       return 5'b01110;
            default: return 5'b00000;
        endcase
    endfunction

    task automatic run_sequence(input int l, input bit xr, input int hold_pct,
                                input bit start_noise, input int hold_idx,
                                input int hold_len, input bit load_chg,
                                input int stop_idx,
                                output int done_cyc, output int done_cnt);
        int idx, cyc, held_used, p;
        bit d, pz, h;
        logic [4:0] act;
        build_sched(l, xr);
        @(negedge clk);
        rst = 1'b0; start = 1'b1; door = 1'b0; pause = 1'b0;
        load = l[1:0]; extra_rinse = xr;
        #1;
        n_tests++;
        if (phase !== 3'd0) begin
            n_fail++;
            $display("FAIL pre_start_idle: phase got %0d expected 0", phase);
        end
        @(posedge clk);
        idx = 0; cyc = 0; held_used = 0; done_cyc = -1; done_cnt = 0;
        while (idx < sched.size() && !(stop_idx >= 0 && idx >= stop_idx)) begin
            @(negedge clk);
            cyc++;
            if (cyc > 20000) begin
                n_tests++; n_fail++;
                $display("FAIL cycle_budget: got %0d cycles, expected completion", cyc);
                break;
            end
            p = sched[idx];
            d = 1'b0; pz = 1'b0;
            if (p >= 1 && p <= 6) begin
                if (hold_idx >= 0 && idx == hold_idx && held_used < hold_len) begin
                    d = 1'b1;
                    held_used++;
                end else if (hold_pct > 0 && $urandom_range(99) < hold_pct) begin
                    if ($urandom_range(1) == 1) d = 1'b1; else pz = 1'b1;
                end
            end
            door = d; pause = pz;
            start = (start_noise && p >= 1 && p <= 6) ? 1'($urandom_range(1)) : 1'b0;
            if (load_chg && idx > 0) begin
                load = 2'd0;
                extra_rinse = ~xr;
            end
            h = (p >= 1 && p <= 6) && (d || pz);
            act = {agitator, motor, pump, speed, water};
            #1;
            act = {agitator, motor, pump, speed, water};
            n_tests++;
            if (phase !== 3'(p)) begin
                n_fail++;
                if (n_fail < 40) $display("FAIL phase cyc=%0d: got %0d expected %0d", cyc, phase, p);
            end
            n_tests++;
            if (held !== h) begin
                n_fail++;
                if (n_fail < 40) $display("FAIL held cyc=%0d: got %b expected %b", cyc, held, h);
            end
            n_tests++;
            if (act !== exp_act(p, h)) begin
                n_fail++;
                if (n_fail < 40) $display("FAIL actuators cyc=%0d: got %b expected %b", cyc, act, exp_act(p, h));
            end
            n_tests++;
            if (door_lock !== (p >= 1 && p <= 6)) begin
                n_fail++;
                if (n_fail < 40) $display("FAIL door_lock cyc=%0d: got %b expected %b", cyc, door_lock, (p >= 1 && p <= 6));
            end
            n_tests++;
            if (done !== (p == 7)) begin
                n_fail++;
                if (n_fail < 40) $display("FAIL done cyc=%0d: got %b expected %b", cyc, done, (p == 7));
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            @(posedge clk);
            if (!h) idx++;
        end
        @(negedge clk);
        start = 1'b0; door = 1'b0; pause = 1'b0;
        $display("[TB] sequence load=%0d xr=%0d: %0d cycles, done at %0d", l, xr, cyc, done_cyc);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b1; door = 1'b1; pause = 1'b1; load = 2'd3; extra_rinse = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        #1;
        n_tests++;
        if (phase !== 3'd0) begin n_fail++; $display("FAIL reset_phase: got %0d expected 0", phase); end
        n_tests++;
        if ({agitator, motor, pump, speed, water, door_lock, held, done} !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 00000000",
                     {agitator, motor, pump, speed, water, door_lock, held, done});
        end
        door = 1'b0; pause = 1'b0;
        $display("[TB] reset checked");
    endtask

    task automatic test_basic();
        int dc, dn;
        run_sequence(0, 1'b0, 0, 1'b0, -1, 0, 1'b0, -1, dc, dn);
        n_tests++;
        if (dc !== 33) begin n_fail++; $display("FAIL basic_done_cycle: got %0d expected 33", dc); end
        n_tests++;
        if (dn !== 1) begin n_fail++; $display("FAIL basic_done_count: got %0d expected 1", dn); end
    endtask

    task automatic test_load3_change();
        int dc, dn;
        run_sequence(3, 1'b0, 0, 1'b0, -1, 0, 1'b1, -1, dc, dn);
        n_tests++;
        if (dc !== 81) begin n_fail++; $display("FAIL load3_done_cycle: got %0d expected 81", dc); end
    endtask

    task automatic test_hold_door();
        int dc, dn;
        // Door opens with three WASH cycles still to run; five frozen cycles.
        run_sequence(0, 1'b0, 0, 1'b0, B + 2 * B - 3, 5, 1'b0, -1, dc, dn);
        n_tests++;
        if (dc !== 38) begin n_fail++; $display("FAIL hold_done_cycle: got %0d expected 38", dc); end
    endtask

    task automatic test_start_blocked();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            start = 1'b1; door = (k == 0); pause = (k == 1);
            for (int c = 0; c < 4; c++) begin
                @(posedge clk);
                @(negedge clk);
                #1;
                n_tests++;
                if (phase !== 3'd0 || door_lock !== 1'b0) begin
                    n_fail++;
                    $display("FAIL start_blocked k=%0d: got phase %0d lock %b expected 0 0", k, phase, door_lock);
                end
            end
        end
        @(negedge clk);
        start = 1'b0; door = 1'b0; pause = 1'b0;
        @(posedge clk);
        $display("[TB] start blocked by door/pause checked");
    endtask

    task automatic test_extra_rinse();
        int dc, dn, exp_dc;
        exp_dc = ext_enabled() ? 41 : 33;
        run_sequence(0, 1'b1, 0, 1'b1, -1, 0, 1'b0, -1, dc, dn);
        n_tests++;
        if (dc !== exp_dc) begin n_fail++; $display("FAIL extra_rinse_done_cycle: got %0d expected %0d", dc, exp_dc); end
    endtask

    task automatic test_reset_in_spin();
        int dc, dn, spin_idx;
        spin_idx = 4 * B * 2 + 2 * B;   // first SPIN cycle with load=1
        run_sequence(1, 1'b0, 0, 1'b1, -1, 0, 1'b0, spin_idx + 3, dc, dn);
        // run_sequence idles inputs one cycle after stopping; SPIN still has cycles left.
        #1;
        n_tests++;
        if (phase !== 3'd6) begin n_fail++; $display("FAIL spin_before_reset: got %0d expected 6", phase); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            #1;
            n_tests++;
            if (phase !== 3'd0 || {agitator, motor, pump, speed, water, door_lock, held, done} !== 8'd0) begin
                n_fail++;
                $display("FAIL reset_in_spin c=%0d: got phase %0d outs %b expected 0 00000000", c, phase,
                         {agitator, motor, pump, speed, water, door_lock, held, done});
            end
            @(negedge clk);
        end
        $display("[TB] reset during SPIN checked");
    endtask

    task automatic test_random();
        int dc, dn, l;
        bit xr, chg;
        for (int it = 0; it < 6; it++) begin
            l   = $urandom_range(3);
            xr  = 1'($urandom_range(1));
            chg = 1'($urandom_range(1));
            run_sequence(l, xr, 20, 1'b1, -1, 0, chg, -1, dc, dn);
            n_tests++;
            if (dn !== 1) begin n_fail++; $display("FAIL random_done_count it=%0d: got %0d expected 1", it, dn); end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; door = 1'b0; pause = 1'b0; load = 2'd0; extra_rinse = 1'b0;
        test_reset();
        test_basic();
        test_load3_change();
        test_hold_door();
        test_start_blocked();
        test_extra_rinse();
        test_reset_in_spin();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
